// File: rtl/sp_ram_reader.sv
// sp_ram_reader: walks sp_ram from a (start, length) command and streams the words out with valid/ready/last
module sp_ram_reader #(
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 8,
   parameter int LEN_WIDTH  = 16,
   localparam int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [LEN_WIDTH-1:0]  cmd_len,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [WIDTH-1:0]      ram_q,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [WIDTH-1:0]      m_data,
   output logic                  m_last,
   output logic                  busy,
   output logic                  done
);
   typedef enum logic [1:0] {IDLE, READ, LAST, FIN} state_t;
   state_t                state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [LEN_WIDTH-1:0]  rem_q, rem_d;
   logic                  arm_q, arm_d;
   logic                  m_valid_q, m_valid_d;
   logic [WIDTH-1:0]      m_data_q, m_data_d;
   logic                  m_last_q, m_last_d;
   logic [ADDR_WIDTH-1:0] ptr_next;
   assign ptr_next  = (ptr_q == ADDR_WIDTH'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
   assign ram_addr  = ptr_q;
   assign cmd_ready = state_q == IDLE;
   assign busy      = state_q != IDLE;
   assign done      = state_q == FIN;
   assign m_valid   = m_valid_q;
   assign m_data    = m_data_q;
   assign m_last    = m_last_q;
   // next state: load command, capture RAM words into the output slot (one settle cycle after load), drain last beat
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      rem_d     = rem_q;
      arm_d     = 1'b0;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_last_d  = m_last_q;
      unique case (state_q)
         IDLE: if (cmd_valid) begin
            ptr_d   = cmd_addr;
            rem_d   = cmd_len;
            arm_d   = 1'b1;
            state_d = (cmd_len == '0) ? FIN : READ;
         end
         READ: if (!arm_q && (!m_valid_q || m_ready)) begin
            m_data_d  = ram_q;
            m_valid_d = 1'b1;
            ptr_d     = ptr_next;
            rem_d     = rem_q - 1'b1;
            if (rem_q == LEN_WIDTH'(1)) begin
               m_last_d = 1'b1;
               state_d  = LAST;
            end
         end
         LAST: if (m_ready) begin
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            state_d   = FIN;
         end
         FIN: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // state registers; reset aborts any command without a done pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         rem_q     <= '0;
         arm_q     <= 1'b0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         rem_q     <= rem_d;
         arm_q     <= arm_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
      end
   end
endmodule

// File: tb/tb_sp_ram_reader.sv
// tb_sp_ram_reader: directed scenario bench for sp_ram_reader with a 6-word RAM model
module tb_sp_ram_reader;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_addr;
   logic [15:0] cmd_len;
   logic [2:0]  ram_addr;
   logic [7:0]  ram_q;
   logic        m_valid;
   logic        m_ready;
   logic [7:0]  m_data;
   logic        m_last;
   logic        busy;
   logic        done;
   logic [7:0]  mem [0:7];
   int          checks = 0;
   int          errors = 0;
   logic [7:0]  got_data [$];
   logic        got_last [$];
   logic [2:0]  got_addr [$];
   int          first_valid_cyc, last_hs_cyc, done_cyc, done_cnt, busy_cycles, stall_err;
   logic        any_valid, timed_out;

   always #5 clk = ~clk;
   assign ram_q = mem[ram_addr];

   sp_ram_reader #(.WIDTH(8), .DEPTH(6), .LEN_WIDTH(16)) dut (
      .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_addr(ram_addr), .ram_q(ram_q),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .done(done)
   );

   // issue one command, then observe one cycle per negedge; c=0 is the negedge right after the accept edge
   task automatic run_cmd(input logic [2:0] a, input logic [15:0] l, input logic [7:0] pat, input int pat_len);
      int k;
      logic pv, pr, pl;
      logic [7:0] pd;
      got_data.delete(); got_last.delete(); got_addr.delete();
      first_valid_cyc = -1; last_hs_cyc = -1; done_cyc = -1;
      done_cnt = 0; busy_cycles = 0; stall_err = 0; any_valid = 1'b0; timed_out = 1'b0;
      k = 0;
      cmd_addr = a; cmd_len = l; cmd_valid = 1'b1;
      while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      got_addr.push_back(ram_addr);
      pv = 1'b0; pr = 1'b1; pd = '0; pl = 1'b0;
      for (int c = 0; c < 60; c++) begin
         if (c > 0) @(negedge clk);
         m_ready = (c < pat_len) ? pat[c] : 1'b1;
         if (ram_addr !== got_addr[$]) got_addr.push_back(ram_addr);
         if (pv && !pr && (m_valid !== 1'b1 || m_data !== pd || m_last !== pl)) stall_err++;
         if (m_valid === 1'b1) begin
            any_valid = 1'b1;
            if (first_valid_cyc < 0) first_valid_cyc = c;
         end
         if (busy === 1'b1) busy_cycles++;
         if (done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (m_valid === 1'b1 && m_ready) begin
            got_data.push_back(m_data);
            got_last.push_back(m_last);
            last_hs_cyc = c;
         end
         pv = m_valid; pr = m_ready; pd = m_data; pl = m_last;
         if (done_cyc >= 0 && c >= done_cyc + 3) break;
      end
      if (done_cyc < 0) timed_out = 1'b1;
      m_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; cmd_valid = 1'b0; cmd_addr = '0; cmd_len = '0; m_ready = 1'b1;
      #12;
      checks++;
      if ({cmd_ready, m_valid, m_last, busy, done} !== 5'b10000) begin
         errors++;
         $display("FAIL reset_ctrl: got ready/valid/last/busy/done=%b expected 10000", {cmd_ready, m_valid, m_last, busy, done});
      end
      checks++;
      if (ram_addr !== 3'd0 || m_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_regs: got ram_addr=%0d m_data=%h expected 0/00", ram_addr, m_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [7:0] exp_d [4] = '{8'h12, 8'h13, 8'h14, 8'h15};
      logic [7:0] gd;
      logic       gl;
      run_cmd(3'd2, 16'd4, 8'h00, 0);
      checks++;
      if (timed_out || got_data.size() != 4) begin
         errors++;
         $display("FAIL basic_count: got %0d beats (timeout=%b) expected 4", got_data.size(), timed_out);
      end
      for (int i = 0; i < 4; i++) begin
         gd = (i < got_data.size()) ? got_data[i] : 8'hxx;
         gl = (i < got_last.size()) ? got_last[i] : 1'bx;
         checks++;
         if (gd !== exp_d[i] || gl !== (i == 3)) begin
            errors++;
            $display("FAIL basic_beat[%0d]: got data=%h last=%b expected %h/%b", i, gd, gl, exp_d[i], i == 3);
         end
      end
      checks++;
      if (first_valid_cyc != 2 || last_hs_cyc != 5) begin
         errors++;
         $display("FAIL basic_timing: got first_valid=%0d last_hs=%0d expected 2/5", first_valid_cyc, last_hs_cyc);
      end
      checks++;
      if (done_cyc != last_hs_cyc + 1 || done_cnt != 1) begin
         errors++;
         $display("FAIL basic_done: got done_cyc=%0d count=%0d expected %0d/1", done_cyc, done_cnt, last_hs_cyc + 1);
      end
   endtask

   task automatic test_wrap();
      logic [2:0] exp_a [5] = '{3'd4, 3'd5, 3'd0, 3'd1, 3'd2};
      logic [7:0] exp_d [5] = '{8'h14, 8'h15, 8'h10, 8'h11, 8'h12};
      logic [7:0] gd;
      logic [2:0] ga;
      logic       gl;
      run_cmd(3'd4, 16'd5, 8'h00, 0);
      for (int i = 0; i < 5; i++) begin
         gd = (i < got_data.size()) ? got_data[i] : 8'hxx;
         gl = (i < got_last.size()) ? got_last[i] : 1'bx;
         ga = (i < got_addr.size()) ? got_addr[i] : 3'bxxx;
         checks++;
         if (gd !== exp_d[i] || gl !== (i == 4) || ga !== exp_a[i]) begin
            errors++;
            $display("FAIL wrap_beat[%0d]: got addr=%0d data=%h last=%b expected %0d/%h/%b", i, ga, gd, gl, exp_a[i], exp_d[i], i == 4);
         end
      end
      checks++;
      if (got_data.size() != 5 || done_cnt != 1) begin
         errors++;
         $display("FAIL wrap_count: got beats=%0d done=%0d expected 5/1", got_data.size(), done_cnt);
      end
   endtask

   task automatic test_backpressure();
      logic [7:0] exp_d [3] = '{8'h11, 8'h12, 8'h13};
      logic [7:0] gd;
      logic       gl;
      run_cmd(3'd1, 16'd3, 8'h29, 6);
      checks++;
      if (got_data.size() != 3 || stall_err != 0) begin
         errors++;
         $display("FAIL bp_stream: got beats=%0d stall_violations=%0d expected 3/0", got_data.size(), stall_err);
      end
      for (int i = 0; i < 3; i++) begin
         gd = (i < got_data.size()) ? got_data[i] : 8'hxx;
         gl = (i < got_last.size()) ? got_last[i] : 1'bx;
         checks++;
         if (gd !== exp_d[i] || gl !== (i == 2)) begin
            errors++;
            $display("FAIL bp_beat[%0d]: got data=%h last=%b expected %h/%b", i, gd, gl, exp_d[i], i == 2);
         end
      end
      checks++;
      if (last_hs_cyc != 6 || done_cyc != 7) begin
         errors++;
         $display("FAIL bp_timing: got last_hs=%0d done=%0d expected 6/7", last_hs_cyc, done_cyc);
      end
   endtask

   task automatic test_zero_len();
      run_cmd(3'd3, 16'd0, 8'h00, 0);
      checks++;
      if (any_valid || got_data.size() != 0) begin
         errors++;
         $display("FAIL zero_stream: got valid_seen=%b beats=%0d expected 0/0", any_valid, got_data.size());
      end
      checks++;
      if (done_cnt != 1 || done_cyc != 0 || busy_cycles != 1) begin
         errors++;
         $display("FAIL zero_done: got done_cnt=%0d done_cyc=%0d busy_cycles=%0d expected 1/0/1", done_cnt, done_cyc, busy_cycles);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_d [3] = '{8'h10, 8'h11, 8'h15};
      logic       exp_l [3] = '{1'b0, 1'b1, 1'b1};
      logic [7:0] gd;
      logic       gl;
      int k, acc_cyc, dc1, dlast, dcnt;
      got_data.delete(); got_last.delete();
      k = 0; acc_cyc = -1; dc1 = -1; dlast = -1; dcnt = 0;
      m_ready = 1'b1; cmd_addr = 3'd0; cmd_len = 16'd2; cmd_valid = 1'b1;
      while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
      cmd_addr = 3'd5; cmd_len = 16'd1;
      for (int c = 0; c < 40; c++) begin
         if (c > 0) @(negedge clk);
         if (done === 1'b1) begin
            dcnt++;
            dlast = c;
            if (dc1 < 0) dc1 = c;
         end
         if (m_valid === 1'b1 && m_ready) begin
            got_data.push_back(m_data);
            got_last.push_back(m_last);
         end
         if (cmd_valid && cmd_ready === 1'b1 && acc_cyc < 0) acc_cyc = c;
         else if (acc_cyc >= 0 && c == acc_cyc + 1) cmd_valid = 1'b0;
         if (dcnt == 2 && c > dlast + 2) break;
      end
      cmd_valid = 1'b0;
      checks++;
      if (dc1 < 0 || acc_cyc != dc1 + 1) begin
         errors++;
         $display("FAIL b2b_accept: got accept_cyc=%0d first_done=%0d expected accept one cycle after done", acc_cyc, dc1);
      end
      checks++;
      if (dcnt != 2 || got_data.size() != 3) begin
         errors++;
         $display("FAIL b2b_count: got done=%0d beats=%0d expected 2/3", dcnt, got_data.size());
      end
      for (int i = 0; i < 3; i++) begin
         gd = (i < got_data.size()) ? got_data[i] : 8'hxx;
         gl = (i < got_last.size()) ? got_last[i] : 1'bx;
         checks++;
         if (gd !== exp_d[i] || gl !== exp_l[i]) begin
            errors++;
            $display("FAIL b2b_beat[%0d]: got data=%h last=%b expected %h/%b", i, gd, gl, exp_d[i], exp_l[i]);
         end
      end
   endtask

   task automatic test_mid_reset();
      int k;
      logic done_seen;
      k = 0; done_seen = 1'b0;
      m_ready = 1'b0; cmd_addr = 3'd3; cmd_len = 16'd4; cmd_valid = 1'b1;
      while (!cmd_ready && k < 20) begin @(negedge clk); k++; end
      @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (m_valid !== 1'b1 || m_data !== 8'h13 || ram_addr !== 3'd4 || busy !== 1'b1) begin
         errors++;
         $display("FAIL mreset_pre: got valid=%b data=%h addr=%0d busy=%b expected 1/13/4/1", m_valid, m_data, ram_addr, busy);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (m_valid !== 1'b0 || busy !== 1'b0 || ram_addr !== 3'd0 || cmd_ready !== 1'b1 || m_last !== 1'b0) begin
         errors++;
         $display("FAIL mreset_async: got valid=%b busy=%b addr=%0d ready=%b last=%b expected 0/0/0/1/0", m_valid, busy, ram_addr, cmd_ready, m_last);
      end
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (done === 1'b1) done_seen = 1'b1;
      end
      rst_n = 1'b1;
      m_ready = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (done === 1'b1) done_seen = 1'b1;
      end
      checks++;
      if (done_seen || cmd_ready !== 1'b1 || m_valid !== 1'b0) begin
         errors++;
         $display("FAIL mreset_after: got done_seen=%b ready=%b valid=%b expected 0/1/0", done_seen, cmd_ready, m_valid);
      end
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
      test_reset();
      test_basic();
      test_wrap();
      test_backpressure();
      test_zero_len();
      test_back_to_back();
      test_mid_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
